// File: rtl/chdr_deframer.sv
// CHDR deframer: strips the header and optional timestamp lines from a 64-bit
// CHDR stream and presents the payload on a WIDTH-bit stream with sideband on o_tuser.
module chdr_deframer #(
  parameter int WIDTH      = 32,
  parameter bit STRICT_LEN = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [63:0]      i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic [127:0]     o_tuser,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic             err_len
);

  if (WIDTH != 32 && WIDTH != 64) begin : g_bad_width
    $error("chdr_deframer: WIDTH must be 32 or 64");
  end

  localparam int BPW = WIDTH / 8;

  typedef enum logic [1:0] {ST_HEAD, ST_TIME, ST_BODY, ST_DROP} state_t;

  state_t        state, state_nxt;
  logic          half, half_nxt;
  logic [15:0]   remaining, remaining_nxt;
  logic [127:0]  tuser_nxt;
  logic          err_nxt;

  logic          has_time;
  logic [15:0]   pkt_len, hdr_bytes, payload_bytes;
  logic [15:0]   rem_aligned;
  logic          len_last;
  logic          line_done;

  assign has_time      = i_tdata[61];
  assign pkt_len       = i_tdata[47:32];
  assign hdr_bytes     = has_time ? 16'd16 : 16'd8;
  assign payload_bytes = pkt_len - hdr_bytes;

  // Counting is done at 4-byte granularity; the low bits only travel in o_tuser.
  assign rem_aligned = {remaining[15:2], 2'b00};
  assign len_last    = rem_aligned <= 16'(BPW);
  // The current output word consumes the input line (always for 64-bit, upper-only final line for 32-bit).
  assign line_done   = (WIDTH == 64) || half || (STRICT_LEN && len_last);

  if (WIDTH == 64) begin : g_w64
    assign o_tdata = i_tdata;
  end else begin : g_w32
    assign o_tdata = half ? i_tdata[31:0] : i_tdata[63:32];
  end

  always_comb begin
    state_nxt     = state;
    half_nxt      = half;
    remaining_nxt = remaining;
    tuser_nxt     = o_tuser;
    err_nxt       = 1'b0;
    i_tready      = 1'b0;
    o_tvalid      = 1'b0;
    o_tlast       = 1'b0;
    case (state)
      ST_HEAD: begin
        i_tready = 1'b1;
        if (i_tvalid) begin
          tuser_nxt     = {i_tdata[63:48], payload_bytes, i_tdata[31:0], 64'h0};
          remaining_nxt = payload_bytes;
          half_nxt      = 1'b0;
          if (i_tlast) begin
            err_nxt = 1'b1;
          end else if (STRICT_LEN && (pkt_len < hdr_bytes || payload_bytes == 16'd0)) begin
            err_nxt   = 1'b1;
            state_nxt = ST_DROP;
          end else begin
            state_nxt = has_time ? ST_TIME : ST_BODY;
          end
        end
      end
      ST_TIME: begin
        i_tready = 1'b1;
        if (i_tvalid) begin
          tuser_nxt[63:0] = i_tdata;
          if (i_tlast) begin
            err_nxt   = 1'b1;
            state_nxt = ST_HEAD;
          end else begin
            state_nxt = ST_BODY;
          end
        end
      end
      ST_BODY: begin
        o_tvalid = i_tvalid;
        i_tready = o_tready && line_done;
        if (STRICT_LEN) o_tlast = len_last || (line_done && i_tlast);
        else            o_tlast = line_done && i_tlast;
        if (i_tvalid && o_tready) begin
          remaining_nxt = (remaining > 16'(BPW)) ? remaining - 16'(BPW) : 16'd0;
          if (line_done) begin
            half_nxt = 1'b0;
            if (i_tlast) begin
              state_nxt = ST_HEAD;
              err_nxt   = STRICT_LEN && !len_last;
            end else if (STRICT_LEN && len_last) begin
              state_nxt = ST_DROP;
              err_nxt   = 1'b1;
            end
          end else begin
            half_nxt = 1'b1;
          end
        end
      end
      ST_DROP: begin
        i_tready = 1'b1;
        if (i_tvalid && i_tlast) state_nxt = ST_HEAD;
      end
      default: state_nxt = ST_HEAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_HEAD;
      half      <= 1'b0;
      remaining <= 16'd0;
      o_tuser   <= 128'h0;
      err_len   <= 1'b0;
    end else if (clear) begin
      state     <= ST_HEAD;
      half      <= 1'b0;
      remaining <= 16'd0;
      o_tuser   <= 128'h0;
      err_len   <= 1'b0;
    end else begin
      state     <= state_nxt;
      half      <= half_nxt;
      remaining <= remaining_nxt;
      o_tuser   <= tuser_nxt;
      err_len   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_chdr_deframer.sv
// Randomized bench for chdr_deframer at WIDTH=64 and WIDTH=32, checked against a
// packet-level model that derives the expected word list from header length and line count.
module tb_chdr_deframer;

  typedef struct {
    logic [63:0]  data;
    logic         last;
    logic [127:0] user;
  } word_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, clear;
  logic [63:0] in_data;
  logic        in_last, in_valid, out_ready;
  int          cur_w;

  logic        rdy64, rdy32, ov64, ov32, ol64, ol32, e64, e32;
  logic [63:0] od64;
  logic [31:0] od32;
  logic [127:0] ou64, ou32;

  logic        act_ready, act_valid, act_last, act_err;
  logic [63:0] act_data;
  logic [127:0] act_user;

  int    checks = 0, errors = 0, err_seen = 0, exp_err = 0;
  word_t exp_q[$];
  logic [63:0] pkt_lines[$];
  bit    check_en = 0, hold_ready = 0;
  int    ready_pct = 100;

  chdr_deframer #(.WIDTH(64), .STRICT_LEN(1'b1)) dut64 (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .i_tdata(in_data), .i_tlast(in_last), .i_tvalid(in_valid && (cur_w == 0)), .i_tready(rdy64),
    .o_tdata(od64), .o_tuser(ou64), .o_tlast(ol64), .o_tvalid(ov64), .o_tready(out_ready),
    .err_len(e64)
  );

  chdr_deframer #(.WIDTH(32), .STRICT_LEN(1'b1)) dut32 (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .i_tdata(in_data), .i_tlast(in_last), .i_tvalid(in_valid && (cur_w == 1)), .i_tready(rdy32),
    .o_tdata(od32), .o_tuser(ou32), .o_tlast(ol32), .o_tvalid(ov32), .o_tready(out_ready),
    .err_len(e32)
  );

  always_comb begin
    if (cur_w == 0) begin
      act_ready = rdy64; act_valid = ov64; act_last = ol64; act_err = e64;
      act_data  = od64;  act_user  = ou64;
    end else begin
      act_ready = rdy32; act_valid = ov32; act_last = ol32; act_err = e32;
      act_data  = {32'h0, od32}; act_user = ou32;
    end
  end

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Downstream ready is re-randomized every cycle unless held low.
  always @(posedge clk) begin
    #1;
    out_ready = hold_ready ? 1'b0 : ($urandom_range(0, 99) < ready_pct);
  end

  logic        prev_stall = 1'b0;
  logic [63:0] prev_data;
  logic        prev_last;

  always @(negedge clk) begin : compare
    word_t e;
    if (check_en) begin
      if (prev_stall && act_valid) begin
        checkOutput("hold_data", act_data, prev_data);
        checkOutput("hold_last", act_last, prev_last);
      end
      if (act_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL extra_word: got %0h expected none", act_data);
        end else begin
          e = exp_q.pop_front();
          checkOutput("o_tdata", act_data, e.data);
          checkOutput("o_tlast", act_last, e.last);
          checkOutput("o_tuser", act_user, e.user);
        end
      end
      if (act_err) err_seen++;
    end
    prev_stall = act_valid && !out_ready;
    prev_data  = act_data;
    prev_last  = act_last;
  end

  // Expected output of one packet, from header length versus number of payload lines.
  task automatic modelPacket(input logic [63:0] hdr, input logic [63:0] ts);
    int nl = pkt_lines.size();
    int hb = hdr[61] ? 16 : 8;
    int len = int'(hdr[47:32]);
    logic [15:0] pb = hdr[47:32] - 16'(hb);
    int bpw = (cur_w == 0) ? 8 : 4;
    int wpl = (cur_w == 0) ? 1 : 2;
    int need, avail, n;
    word_t wd;
    if (nl == 0 || len < hb || pb == 16'd0) begin
      exp_err++;
      return;
    end
    need = ((int'(pb) / 4) * 4 + bpw - 1) / bpw;
    if (need < 1) need = 1;
    avail = nl * wpl;
    n = (need < avail) ? need : avail;
    for (int k = 0; k < n; k++) begin
      if (cur_w == 0) wd.data = pkt_lines[k];
      else if (k % 2 == 0) wd.data = {32'h0, pkt_lines[k/2][63:32]};
      else wd.data = {32'h0, pkt_lines[k/2][31:0]};
      wd.last = (k == n - 1);
      wd.user = {hdr[63:48], pb, hdr[31:0], hdr[61] ? ts : 64'h0};
      exp_q.push_back(wd);
    end
    if (need > avail || (n - 1) / wpl != nl - 1) exp_err++;
  endtask

  task automatic applyStimulus(input logic [63:0] d, input logic l);
    int t = 0;
    in_data = d; in_last = l; in_valid = 1'b1;
    @(negedge clk);
    while (!act_ready) begin
      t++;
      if (t > 500) begin
        checks++; errors++;
        $display("[TB] FAIL in_ready_timeout: got 0 expected 1");
        break;
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if ($urandom_range(0, 3) == 0) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic runPacket(input logic [63:0] hdr, input logic [63:0] ts);
    int n = pkt_lines.size();
    applyStimulus(hdr, (n == 0) && !hdr[61]);
    if (hdr[61]) applyStimulus(ts, n == 0);
    for (int i = 0; i < n; i++) applyStimulus(pkt_lines[i], i == n - 1);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    checkOutput("leftover_words", exp_q.size(), 0);
    checkOutput("err_len_count", err_seen, exp_err);
  endtask

  task automatic randomPacket(input int w, input int nl_fixed);
    int nl, hb, pb, len;
    bit ht;
    logic [15:0] hi;
    logic [63:0] hdr, ts;
    cur_w = w;
    ht = 1'($urandom_range(0, 1));
    hb = ht ? 16 : 8;
    nl = (nl_fixed > 0) ? nl_fixed : int'($urandom_range(1, 6));
    pb = nl * 8;
    if (nl_fixed == 0) begin
      case ($urandom_range(0, 6))
        3: pb = nl * 8 - 4;
        4: pb = int'($urandom_range(1, 60));
        5: pb = -int'($urandom_range(0, hb));
        6: nl = 0;
        default: pb = nl * 8;
      endcase
    end
    len = hb + pb;
    hi = 16'($urandom);
    hi[13] = ht;
    ts = {$urandom, $urandom};
    hdr = {hi, 16'(len), $urandom};
    pkt_lines.delete();
    for (int i = 0; i < nl; i++) pkt_lines.push_back({$urandom, $urandom});
    modelPacket(hdr, ts);
    runPacket(hdr, ts);
  endtask

  // Abort a packet mid-body by reset or clear, then decode a fresh packet.
  task automatic interruptTest(input int w, input bit use_reset);
    check_en = 0; cur_w = w; hold_ready = 1;
    @(posedge clk); #1;
    applyStimulus({16'h0000, 16'd40, 32'h0}, 1'b0);
    in_data = 64'hDEAD_BEEF_0BAD_F00D; in_last = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    checkOutput("intr_valid_before", act_valid, 1);
    if (use_reset) begin
      #2 reset_n = 1'b0;
      #1;
    end else begin
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
    end
    checkOutput("intr_o_tvalid", act_valid, 0);
    checkOutput("intr_o_tlast", act_last, 0);
    checkOutput("intr_o_tuser", act_user, 0);
    checkOutput("intr_err_len", act_err, 0);
    in_valid = 1'b0;
    exp_q.delete(); err_seen = 0; exp_err = 0;
    #1 reset_n = 1'b1;
    hold_ready = 0;
    @(posedge clk); #1;
    check_en = 1;
    pkt_lines.delete();
    pkt_lines.push_back(64'h0102030405060708);
    pkt_lines.push_back(64'h1112131415161718);
    modelPacket({16'h2ABC, 16'd32, 32'hCAFE0001}, 64'h0F0E0D0C0B0A0908);
    runPacket({16'h2ABC, 16'd32, 32'hCAFE0001}, 64'h0F0E0D0C0B0A0908);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int e0;
    logic [63:0] hdr;
    reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = 64'h0; in_last = 1'b0; cur_w = 0;
    #12;
    for (int w = 0; w < 2; w++) begin
      cur_w = w;
      #1;
      checkOutput("rst_o_tvalid", act_valid, 0);
      checkOutput("rst_o_tlast", act_last, 0);
      checkOutput("rst_o_tuser", act_user, 0);
      checkOutput("rst_err_len", act_err, 0);
    end
    cur_w = 0;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_en = 1;

    // 64-bit, no timestamp, 24 payload bytes in three lines
    pkt_lines.delete();
    pkt_lines.push_back(64'hD0D0D0D0_00000000);
    pkt_lines.push_back(64'hD1D1D1D1_11111111);
    pkt_lines.push_back(64'hD2D2D2D2_22222222);
    hdr = {16'h0000, 16'd32, 32'h12345678};
    e0 = exp_err;
    modelPacket(hdr, 64'h0);
    checkOutput("pin1_count", exp_q.size(), 3);
    checkOutput("pin1_last_data", exp_q[2].data, 64'hD2D2D2D2_22222222);
    checkOutput("pin1_last_flag", exp_q[2].last, 1);
    checkOutput("pin1_payload_bytes", exp_q[0].user[111:96], 24);
    checkOutput("pin1_ts", exp_q[0].user[63:0], 0);
    checkOutput("pin1_err", exp_err - e0, 0);
    runPacket(hdr, 64'h0);

    // 64-bit with timestamp, single payload line
    pkt_lines.delete();
    pkt_lines.push_back(64'hABCDEF01_23456789);
    hdr = {16'h2000, 16'd24, 32'h0000_0042};
    modelPacket(hdr, 64'h1122334455667788);
    checkOutput("pin2_count", exp_q.size(), 1);
    checkOutput("pin2_ts", exp_q[0].user[63:0], 64'h1122334455667788);
    checkOutput("pin2_payload_bytes", exp_q[0].user[111:96], 8);
    checkOutput("pin2_last_flag", exp_q[0].last, 1);
    runPacket(hdr, 64'h1122334455667788);

    // Header says 16 bytes but three payload lines follow
    pkt_lines.delete();
    for (int i = 0; i < 3; i++) pkt_lines.push_back({32'hE0E0E0E0, 32'(i)});
    hdr = {16'h0000, 16'd16, 32'h0};
    e0 = exp_err;
    modelPacket(hdr, 64'h0);
    checkOutput("pin5_count", exp_q.size(), 1);
    checkOutput("pin5_err", exp_err - e0, 1);
    runPacket(hdr, 64'h0);
    pkt_lines.delete();
    pkt_lines.push_back(64'h5555666677778888);
    modelPacket({16'h0001, 16'd16, 32'h9}, 64'h0);
    runPacket({16'h0001, 16'd16, 32'h9}, 64'h0);

    // 32-bit, 12 payload bytes: last line yields only its upper word
    cur_w = 1;
    pkt_lines.delete();
    pkt_lines.push_back(64'hAAAAAAAA_BBBBBBBB);
    pkt_lines.push_back(64'hCCCCCCCC_DDDDDDDD);
    hdr = {16'h0000, 16'd20, 32'h0};
    e0 = exp_err;
    modelPacket(hdr, 64'h0);
    checkOutput("pin3_count", exp_q.size(), 3);
    checkOutput("pin3_word0", exp_q[0].data, 64'hAAAAAAAA);
    checkOutput("pin3_word2", exp_q[2].data, 64'hCCCCCCCC);
    checkOutput("pin3_last_flag", exp_q[2].last, 1);
    checkOutput("pin3_err", exp_err - e0, 0);
    runPacket(hdr, 64'h0);

    // Long packets under heavy downstream back-pressure
    ready_pct = 50;
    randomPacket(0, 64);
    randomPacket(1, 64);

    for (int w = 0; w < 2; w++) begin
      for (int p = 0; p < 30; p++) begin
        ready_pct = int'($urandom_range(40, 100));
        randomPacket(w, 0);
      end
    end
    ready_pct = 100;

    interruptTest(0, 1'b1);
    interruptTest(1, 1'b0);
    interruptTest(1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/chdr_deframer.md
Name: chdr_deframer

Overview:
- Receive-side counterpart of the CHDR packet framer. Accepts a 64-bit CHDR packet stream and parses the header line and the optional timestamp line into a 128-bit sideband word.
- Emits only the payload on a WIDTH-bit stream, with the sideband held on o_tuser.
- Sits between the crossbar/NoC shell and block user logic. Its o_tuser format is identical to the framer's i_tuser, so the two blocks round-trip.

Parameters:
- WIDTH, 32, output payload width; only 32 or 64 are legal (elaboration error otherwise).
- STRICT_LEN, 1, 1 = trim or drop packets whose header length disagrees with the beat count; 0 = pass beats through to i_tlast and ignore the length field.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous, active-high; returns FSM to ST_HEAD, drops any packet in flight
- i_tdata  in  64  CHDR stream line
- i_tlast  in  1  last line of packet
- i_tvalid  in  1  AXI-stream valid
- i_tready  out  1  AXI-stream ready
- o_tdata  out  WIDTH  payload word
- o_tuser  out  128  {hdr[63:48], payload_bytes[15:0], hdr[31:0], timestamp[63:0]}; constant for the whole packet
- o_tlast  out  1  last payload word
- o_tvalid  out  1  AXI-stream valid
- o_tready  in  1  AXI-stream ready
- err_len  out  1  one-cycle pulse on a length mismatch or malformed packet

Behaviour:
- Reset (reset_n low, asynchronous) and clear (synchronous):
  - o_tvalid=0, o_tlast=0, o_tuser=0, err_len=0, state=ST_HEAD, half=0, remaining=0.
- Header fields:
  - hdr[61] = has_time; hdr[47:32] = total packet length in bytes.
  - hdr_bytes = has_time ? 16 : 8.
  - payload_bytes = length - hdr_bytes, 16-bit unsigned.
- ST_HEAD:
  - i_tready=1, o_tvalid=0.
  - On handshake: latch o_tuser[127:64] with payload_bytes substituted in [111:96]; zero o_tuser[63:0]; remaining <= payload_bytes.
  - Next state = ST_TIME if has_time, else ST_BODY.
  - If i_tlast is also set, or length < hdr_bytes: err_len=1, next = ST_DROP (or ST_HEAD if i_tlast), no output.
  - A length of 0 payload bytes with further beats also takes the error path.
- ST_TIME:
  - i_tready=1.
  - On handshake: o_tuser[63:0] <= i_tdata.
  - i_tlast here: err_len, back to ST_HEAD, no output. Otherwise go to ST_BODY.
- ST_BODY, WIDTH=64:
  - Combinational pass-through: o_tdata=i_tdata, o_tvalid=i_tvalid, i_tready=o_tready.
  - remaining decrements by 8 per transfer, saturating at 0.
- ST_BODY, WIDTH=32:
  - Each line yields two words, upper half i_tdata[63:32] first.
  - half=0: o_tdata=i_tdata[63:32], i_tready=0. On o handshake, half <= 1, unless this is the last word.
  - half=1: o_tdata=i_tdata[31:0], i_tready=o_tready. Handshake consumes the line; half <= 0.
  - remaining decrements by 4 per output word.
  - When remaining==4 at half=0, the last line carries only the upper word: the line is consumed on that word's handshake (i_tready=o_tready) and the lower half is discarded.
- o_tlast:
  - STRICT_LEN=1: asserted on the word where remaining <= WIDTH/8.
    - If i_tlast is not on that line: after the handshake go to ST_DROP and pulse err_len.
    - If i_tlast arrives earlier: o_tlast is forced on that word, err_len pulses, return to ST_HEAD.
  - STRICT_LEN=0: o_tlast = i_tlast (on the final word of the line for WIDTH=32).
- ST_DROP: i_tready=1, o_tvalid=0; return to ST_HEAD after the i_tlast handshake.
- No output bubbles in ST_BODY. Header and timestamp lines cost one input cycle each with no output.
- Length granularity is 4 bytes. Bits [1:0] of payload_bytes are ignored for counting but reported unchanged in o_tuser.
- o_tuser changes only in ST_HEAD and ST_TIME, never while o_tvalid=1.
- Upstream back-pressure: o_tvalid follows i_tvalid. o_tdata and o_tlast must be stable while o_tvalid=1 and o_tready=0.

Test Plan:
- WIDTH=64, no time, hdr length=32 (3 payload lines D0..D2) -> 3 output beats D0..D2, o_tlast on D2, o_tuser[111:96]=24, o_tuser[63:0]=0, err_len never set.
- WIDTH=64, has_time, TS=0x1122334455667788, length=24 -> single beat with o_tlast, o_tuser[63:0]=TS, payload_bytes=8.
- WIDTH=32, no time, length=20 (line 0xAAAAAAAA_BBBBBBBB, then line 0xCCCCCCCC_xxxxxxxx) -> words AAAAAAAA, BBBBBBBB, CCCCCCCC with o_tlast; lower half of the second line dropped.
- o_tready toggled 1-0-1 randomly through a 64-line packet at both widths -> word sequence intact, o_tuser stable, no duplicates or losses.
- STRICT_LEN=1, length=16 but 3 payload lines -> o_tlast on first payload line, err_len pulse, next 2 lines swallowed, following packet parsed correctly.
- reset_n asserted mid-body, then a new packet -> outputs zero immediately with no clock edge needed; new packet decoded from its header.
